// File: rtl/ctrl_multicycle_seq_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface ctrl_multicycle_seq_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       md_done;

  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_wr;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       aluout_write;
  logic       reg_write;
  logic       reg_dst;
  logic [1:0] mem_to_reg;
  logic       md_start;
  logic       md_op;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, md_done,
    output pc_write, pc_write_cond, pc_source, iord, mem_wr, ir_write,
           alu_src_a, alu_src_b, alu_op, aluout_write, reg_write, reg_dst,
           mem_to_reg, md_start, md_op, illegal
  );

  modport slave (
    output opcode, funct, zero, md_done,
    input  pc_write, pc_write_cond, pc_source, iord, mem_wr, ir_write,
           alu_src_a, alu_src_b, alu_op, aluout_write, reg_write, reg_dst,
           mem_to_reg, md_start, md_op, illegal
  );
endinterface

// File: rtl/ctrl_multicycle_seq.sv
// Moore control FSM for the multicycle MIPS-subset datapath: fetch/decode/execute/
// memory/write-back sequencing with memory wait states and a mult/div handshake.
module ctrl_multicycle_seq #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  ctrl_multicycle_seq_if.master       bus
);
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_MD_START, S_MD_WAIT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       md_start;
    logic       md_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_DIV    = 6'h1A;

  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       md_op_sel_q, md_op_sel_d;
  logic       illegal_d;
  ctrl_t      ctrl_q, ctrl_d;

  // zero is consumed by the datapath's conditional PC-write gate, not here.
  logic unused_zero;
  assign unused_zero = bus.zero;

  always_comb begin
    state_d     = state_q;
    md_op_sel_d = md_op_sel_q;
    illegal_d   = 1'b0;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (wait_q == WAIT_LAST) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: begin
            case (bus.funct)
              F_ADD, F_SUB, F_AND: state_d = S_EXEC_R;
              F_MULT: begin state_d = S_MD_START; md_op_sel_d = 1'b0; end
              F_DIV:  begin state_d = S_MD_START; md_op_sel_d = 1'b1; end
              default: begin state_d = S_FETCH; illegal_d = 1'b1; end
            endcase
          end
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin state_d = S_FETCH; illegal_d = 1'b1; end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (wait_q == WAIT_LAST) state_d = S_WB_MEM;
      S_MD_START: state_d = S_MD_WAIT;
      S_MD_WAIT:  if (bus.md_done) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_RST;
    endcase

    if (state_d != state_q)       wait_d = '0;
    else if (wait_q == WAIT_LAST) wait_d = wait_q;
    else                          wait_d = wait_q + 3'd1;

    // Outputs are decoded from the next state so the registered copy lines up with it.
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.alu_src_b = 2'b11;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.ir_write  = (wait_d == WAIT_LAST);
        ctrl_d.pc_write  = (wait_d == WAIT_LAST);
        ctrl_d.illegal   = illegal_d;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b    = 2'b10;
        ctrl_d.alu_op       = ALU_ADD;
        ctrl_d.aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a    = 1'b1;
        ctrl_d.aluout_write = 1'b1;
        case (bus.funct)
          F_SUB:   ctrl_d.alu_op = ALU_SUB;
          F_AND:   ctrl_d.alu_op = ALU_AND;
          default: ctrl_d.alu_op = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl_d.alu_src_a    = 1'b1;
        ctrl_d.alu_src_b    = 2'b01;
        ctrl_d.alu_op       = ALU_ADD;
        ctrl_d.aluout_write = 1'b1;
      end
      S_WB_I:   ctrl_d.reg_write = 1'b1;
      S_MEM_RD: ctrl_d.iord = 1'b1;
      S_WB_MEM: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        ctrl_d.iord   = 1'b1;
        ctrl_d.mem_wr = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_source     = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_source = 2'b10;
        ctrl_d.pc_write  = 1'b1;
      end
      S_MD_START: begin
        ctrl_d.md_start = 1'b1;
        ctrl_d.md_op    = md_op_sel_d;
      end
      S_MD_WAIT: ctrl_d.md_op = md_op_sel_d;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RST;
      wait_q      <= '0;
      md_op_sel_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      md_op_sel_q <= md_op_sel_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign bus.pc_write      = ctrl_q.pc_write;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.iord          = ctrl_q.iord;
  assign bus.mem_wr        = ctrl_q.mem_wr;
  assign bus.ir_write      = ctrl_q.ir_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.aluout_write  = ctrl_q.aluout_write;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.md_start      = ctrl_q.md_start;
  assign bus.md_op         = ctrl_q.md_op;
  assign bus.illegal       = ctrl_q.illegal;
endmodule
